p405s_timerctl: RTL and testbench
=================================

# p405s_timerCtl

Watchdog, FIT and PIT event controller for the PPC405 timer facility. Samples selected time-base taps, runs the programmable interval timer decrementer, and produces the single-cycle set strobes (wdPulse, hwSetWdIntrp, hwSetWdRst/wdRstType, hwSetFitStatus, hwSetPitStatus) consumed by p405s_timerStatus. Sequences the watchdog escalation (enable → interrupt → reset) from the current TSR contents, and holds the core reset request after a watchdog reset.

## Interface
- RST_HOLD_CYCLES, 64: number of cycles resetReq stays asserted after a watchdog reset.
- CB  in  1  core clock; all state on posedge.
- resetCoreN  in  1  reset, asynchronous, active-low; clears all state.
- TBL  in  [0:31]  time-base lower word, bit 0 MSB.
- tbEnable  in  1  time base advancing this cycle; gates PIT decrement.
- tcrWp  in  [0:1]  watchdog period select.
- tcrWrc  in  [0:1]  watchdog reset control; 00 = no reset.
- tcrWie, tcrPie, tcrFie  in  1 each  interrupt enables.
- tcrFp  in  [0:1]  FIT period select.
- tcrAre  in  1  PIT auto-reload enable.
- timerStatusOutL2  in  [0:5]  TSR: ENW, WIS, WRS[0:1], PIS, FIS.
- pitWrEn  in  1  mtSPR PIT strobe.
- pitWrData  in  [0:31]  PIT write value.
- pitValue  out  [0:31]  current PIT count (mfSPR).
- wdPulse, hwSetWdIntrp, hwSetWdRst, hwSetFitStatus, hwSetPitStatus  out  1 each  single-cycle strobes to the TSR.
- wdRstType  out  [0:1]  reset type qualifying hwSetWdRst.
- wdIntrpReq, pitIntrpReq, fitIntrpReq  out  1 each  interrupt requests to the interrupt controller.
- resetReq  out  [0:1]  core/chip/system reset request (copy of WRC); 00 = none.

## Operation
- Tap events: WD event = 0→1 transition of TBL[15], [11], [7], [3] for tcrWp 00..11 (periods 2^17..2^29). FIT event = 0→1 of TBL[23], [19], [15], [11] for tcrFp 00..11. Changing the period select updates the previous-tap register to the new tap in the same cycle; a select change never produces an event.
- Watchdog escalation on WD event, decided from the TSR sampled in the event cycle:
  - ENW=0: wdPulse only.
  - ENW=1, WIS=0: wdPulse + hwSetWdIntrp.
  - ENW=1, WIS=1, WRS=00, tcrWrc≠00: hwSetWdRst, wdRstType=tcrWrc, FSM RUN→RST_HOLD.
  - ENW=1, WIS=1, WRC=00 or WRS≠00: wdPulse only; no reset.
- FSM: RUN (reset state); RST_HOLD: resetReq=latched WRC, counter from RST_HOLD_CYCLES-1 down to 0, then back to RUN with resetReq=00. All WD and FIT events are suppressed in RST_HOLD. The PIT keeps running.
- FIT event: hwSetFitStatus.
- PIT: 32-bit down-counter plus a 32-bit reload register; pitWrEn loads both.
  - On tbEnable with count>1: decrement.
  - count==1: hwSetPitStatus; next value = reload if tcrAre, else 0.
  - count==0: hold; no event.
  - pitWrEn has priority over decrement in the same cycle; writing 0 produces no event.
- Interrupt requests (registered): wdIntrpReq=WIS&tcrWie, pitIntrpReq=PIS&tcrPie, fitIntrpReq=FIS&tcrFie.
- Reset values: every strobe 0, wdRstType=00, resetReq=00, pitValue=0, reload=0, FSM RUN, previous-tap registers 0, interrupt requests 0.

## Timing
- TBL tap sampled in cycle N showing the transition → strobe asserted in cycle N+1 for exactly one cycle.
- The TSR update lands in N+2 (TSR register). Back-to-back events therefore see the updated TSR, since the minimum event spacing is ≥2^9 cycles.
- PIT: count 1 sampled with tbEnable in N → hwSetPitStatus in N+1; pitValue shows reload/0 in N+1.
- pitWrEn in N → pitValue=pitWrData in N+1.
- resetReq asserts in the same cycle as hwSetWdRst and stays asserted for exactly RST_HOLD_CYCLES cycles.
- Interrupt requests lag the TSR by one cycle.
- Asynchronous reset mid-RST_HOLD: resetReq drops immediately; FSM returns to RUN.

## Structure
- Package p405s_timerPkg:
  - TSR bit indices (ENW=0, WIS=1, WRS=2:3, PIS=4, FIS=5).
  - WD and FIT tap index constants.
  - FSM state encoding.
  - RST_HOLD_CYCLES default.
- Sub-module p405s_timerTap: 4:1 tap mux plus previous-tap register and rising-edge detect, suppressed on select change. Instantiated twice (WD, FIT).
- The top level holds the escalation logic, FSM/hold counter, PIT counter/reload, and output registers.

## Test plan
- WD escalation: tcrWp=00, WRC=10, TSR fed back through p405s_timerStatus → three successive TBL[15] rises give ENW set, then WIS set with wdIntrpReq (tcrWie=1), then hwSetWdRst with wdRstType=10 and resetReq=10 held 64 cycles, then 00.
- WRC=00 with ENW=WIS=1: WD event → wdPulse only, resetReq stays 00.
- FIT: tcrFp=01, TBL[19] 0→1 → hwSetFitStatus one cycle later; tcrFp changed 01→00 while TBL[23]=1 → no strobe.
- PIT auto-reload: write 3, tcrAre=1, tbEnable=1 → pitValue 3,2,1,3; hwSetPitStatus pulses once per reload. With tcrAre=0 → 3,2,1,0 then holds at 0 with no further event.
- PIT write collision: pitWrEn=5 in the same cycle count=1 with tbEnable → pitValue=5, no hwSetPitStatus.
- resetCoreN low during RST_HOLD (cycle 10) → resetReq=00 immediately. A subsequent WD event while ENW=0 gives wdPulse only.

Source files
------------

// File: rtl/p405s_timerctl_pkg.sv
// Shared constants for the PPC405 timer event controller: TSR field positions,
// time-base tap selections and the reset-hold FSM encoding.
package p405s_timerPkg;

    localparam int TSR_ENW  = 0;
    localparam int TSR_WIS  = 1;
    localparam int TSR_WRS0 = 2;
    localparam int TSR_WRS1 = 3;
    localparam int TSR_PIS  = 4;
    localparam int TSR_FIS  = 5;

    // TBL bit numbers (bit 0 = MSB) for period selects 00..11
    localparam int WD_TAP_0  = 15;
    localparam int WD_TAP_1  = 11;
    localparam int WD_TAP_2  = 7;
    localparam int WD_TAP_3  = 3;
    localparam int FIT_TAP_0 = 23;
    localparam int FIT_TAP_1 = 19;
    localparam int FIT_TAP_2 = 15;
    localparam int FIT_TAP_3 = 11;

    localparam int RST_HOLD_CYCLES_DEF = 64;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_RST_HOLD = 1'b1
    } tctl_state_e;

endpackage

// File: rtl/p405s_timerctl_tap.sv
// Time-base tap selector with rising-edge detect; a change of the select
// re-seeds the history so switching taps can never fake an edge.
module p405s_timerTap (
    input  logic       CB,
    input  logic       resetCoreN,
    input  logic [3:0] taps,
    input  logic [1:0] sel,
    output logic       rise
);

    logic       tap_cur;
    logic       prev_tap_d, prev_tap_q;
    logic [1:0] sel_d, sel_q;

    always_comb begin
        tap_cur    = taps[sel];
        prev_tap_d = tap_cur;
        sel_d      = sel;
        rise       = tap_cur & ~prev_tap_q & (sel == sel_q);
    end

    always_ff @(posedge CB or negedge resetCoreN) begin
        if (!resetCoreN) begin
            prev_tap_q <= 1'b0;
            sel_q      <= 2'b00;
        end else begin
            prev_tap_q <= prev_tap_d;
            sel_q      <= sel_d;
        end
    end

endmodule

// File: rtl/p405s_timerctl.sv
// Watchdog / FIT / PIT event controller: turns time-base taps and the PIT
// decrementer into one-cycle TSR set strobes and sequences watchdog reset.
module p405s_timerctl
    import p405s_timerPkg::*;
#(
    parameter int RST_HOLD_CYCLES = RST_HOLD_CYCLES_DEF
) (
    input  logic        CB,
    input  logic        resetCoreN,
    input  logic [0:31] TBL,
    input  logic        tbEnable,
    input  logic [0:1]  tcrWp,
    input  logic [0:1]  tcrWrc,
    input  logic        tcrWie,
    input  logic        tcrPie,
    input  logic        tcrFie,
    input  logic [0:1]  tcrFp,
    input  logic        tcrAre,
    input  logic [0:5]  timerStatusOutL2,
    input  logic        pitWrEn,
    input  logic [0:31] pitWrData,
    output logic [0:31] pitValue,
    output logic        wdPulse,
    output logic        hwSetWdIntrp,
    output logic        hwSetWdRst,
    output logic        hwSetFitStatus,
    output logic        hwSetPitStatus,
    output logic [0:1]  wdRstType,
    output logic        wdIntrpReq,
    output logic        pitIntrpReq,
    output logic        fitIntrpReq,
    output logic [0:1]  resetReq
);

    localparam int CW = $clog2(RST_HOLD_CYCLES + 1);

    logic wd_rise, fit_rise, run;
    logic tbl_unused;

    tctl_state_e state_d, state_q;
    logic [CW-1:0] hold_cnt_d, hold_cnt_q;
    logic [1:0]    wrc_d, wrc_q;
    logic [31:0]   pit_cnt_d, pit_cnt_q, pit_reload_d, pit_reload_q;
    logic          wd_pulse_d, wd_pulse_q, wd_intrp_d, wd_intrp_q, wd_rst_d, wd_rst_q;
    logic [1:0]    wd_rst_type_d, wd_rst_type_q;
    logic          fit_set_d, fit_set_q, pit_set_d, pit_set_q;
    logic          wd_irq_d, wd_irq_q, pit_irq_d, pit_irq_q, fit_irq_d, fit_irq_q;

    // Only the six tap bits matter; fold the rest so lint sees them consumed.
    assign tbl_unused = ^TBL;

    p405s_timerTap u_wd_tap (
        .CB         (CB),
        .resetCoreN (resetCoreN),
        .taps       ({TBL[WD_TAP_3], TBL[WD_TAP_2], TBL[WD_TAP_1], TBL[WD_TAP_0]}),
        .sel        (tcrWp),
        .rise       (wd_rise)
    );

    p405s_timerTap u_fit_tap (
        .CB         (CB),
        .resetCoreN (resetCoreN),
        .taps       ({TBL[FIT_TAP_3], TBL[FIT_TAP_2], TBL[FIT_TAP_1], TBL[FIT_TAP_0]}),
        .sel        (tcrFp),
        .rise       (fit_rise)
    );

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        wrc_d         = wrc_q;
        pit_cnt_d     = pit_cnt_q;
        pit_reload_d  = pit_reload_q;
        wd_pulse_d    = 1'b0;
        wd_intrp_d    = 1'b0;
        wd_rst_d      = 1'b0;
        wd_rst_type_d = 2'b00;
        pit_set_d     = 1'b0;
        run           = (state_q == ST_RUN);
        fit_set_d     = fit_rise & run;

        if (wd_rise && run) begin
            if (!timerStatusOutL2[TSR_ENW]) begin
                wd_pulse_d = 1'b1;
            end else if (!timerStatusOutL2[TSR_WIS]) begin
                wd_pulse_d = 1'b1;
                wd_intrp_d = 1'b1;
            end else if (timerStatusOutL2[TSR_WRS0:TSR_WRS1] == 2'b00 && tcrWrc != 2'b00) begin
                wd_rst_d      = 1'b1;
                wd_rst_type_d = tcrWrc;
                wrc_d         = tcrWrc;
                state_d       = ST_RST_HOLD;
                hold_cnt_d    = CW'(RST_HOLD_CYCLES - 1);
            end else begin
                // Reset disabled or already recorded: the event is only a tick.
                wd_pulse_d = 1'b1;
            end
        end

        if (state_q == ST_RST_HOLD) begin
            if (hold_cnt_q == '0) begin
                state_d = ST_RUN;
            end else begin
                hold_cnt_d = hold_cnt_q - 1'b1;
            end
        end

        if (pitWrEn) begin
            pit_cnt_d    = pitWrData;
            pit_reload_d = pitWrData;
        end else if (tbEnable) begin
            if (pit_cnt_q > 32'd1) begin
                pit_cnt_d = pit_cnt_q - 32'd1;
            end else if (pit_cnt_q == 32'd1) begin
                pit_set_d = 1'b1;
                pit_cnt_d = tcrAre ? pit_reload_q : 32'd0;
            end
        end

        wd_irq_d  = timerStatusOutL2[TSR_WIS] & tcrWie;
        pit_irq_d = timerStatusOutL2[TSR_PIS] & tcrPie;
        fit_irq_d = timerStatusOutL2[TSR_FIS] & tcrFie;
    end

    always_ff @(posedge CB or negedge resetCoreN) begin
        if (!resetCoreN) begin
            state_q       <= ST_RUN;
            hold_cnt_q    <= '0;
            wrc_q         <= 2'b00;
            pit_cnt_q     <= 32'd0;
            pit_reload_q  <= 32'd0;
            wd_pulse_q    <= 1'b0;
            wd_intrp_q    <= 1'b0;
            wd_rst_q      <= 1'b0;
            wd_rst_type_q <= 2'b00;
            fit_set_q     <= 1'b0;
            pit_set_q     <= 1'b0;
            wd_irq_q      <= 1'b0;
            pit_irq_q     <= 1'b0;
            fit_irq_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            wrc_q         <= wrc_d;
            pit_cnt_q     <= pit_cnt_d;
            pit_reload_q  <= pit_reload_d;
            wd_pulse_q    <= wd_pulse_d;
            wd_intrp_q    <= wd_intrp_d;
            wd_rst_q      <= wd_rst_d;
            wd_rst_type_q <= wd_rst_type_d;
            fit_set_q     <= fit_set_d;
            pit_set_q     <= pit_set_d;
            wd_irq_q      <= wd_irq_d;
            pit_irq_q     <= pit_irq_d;
            fit_irq_q     <= fit_irq_d;
        end
    end

    assign pitValue       = pit_cnt_q;
    assign wdPulse        = wd_pulse_q;
    assign hwSetWdIntrp   = wd_intrp_q;
    assign hwSetWdRst     = wd_rst_q;
    assign wdRstType      = wd_rst_type_q;
    assign hwSetFitStatus = fit_set_q;
    assign hwSetPitStatus = pit_set_q;
    assign wdIntrpReq     = wd_irq_q;
    assign pitIntrpReq    = pit_irq_q;
    assign fitIntrpReq    = fit_irq_q;
    // Reset request is tied to the hold state so an async reset drops it at once.
    assign resetReq       = (state_q == ST_RST_HOLD) ? wrc_q : 2'b00;

endmodule

// File: tb/tb_p405s_timerctl.sv
// Scoreboard bench for p405s_timerctl: a per-cycle reference model pushes the
// expected output vector; an independent monitor pops and compares each cycle.
module tb_p405s_timerctl;

    localparam int HOLD = 64;

    typedef struct packed {
        logic        wd_pulse;
        logic        wd_intrp;
        logic        wd_rst;
        logic [1:0]  rst_type;
        logic        fit;
        logic        pit;
        logic        wd_irq;
        logic        pit_irq;
        logic        fit_irq;
        logic [1:0]  reset_req;
        logic [31:0] pit_value;
    } obs_t;

    logic        CB = 1'b0;
    logic        resetCoreN = 1'b0;
    logic [31:0] tbl_v = '0;
    logic        tb_en = 1'b0, wie = 1'b0, pie = 1'b0, fie = 1'b0, are = 1'b0, pit_we = 1'b0;
    logic [1:0]  wp = '0, fp = '0, wrc = '0;
    logic [31:0] pit_data = '0;
    logic [0:5]  tsr = '0;

    logic [0:31] pitValue;
    logic        wdPulse, hwSetWdIntrp, hwSetWdRst, hwSetFitStatus, hwSetPitStatus;
    logic [0:1]  wdRstType, resetReq;
    logic        wdIntrpReq, pitIntrpReq, fitIntrpReq;

    p405s_timerctl #(.RST_HOLD_CYCLES(HOLD)) dut (
        .CB               (CB),
        .resetCoreN       (resetCoreN),
        .TBL              (tbl_v),
        .tbEnable         (tb_en),
        .tcrWp            (wp),
        .tcrWrc           (wrc),
        .tcrWie           (wie),
        .tcrPie           (pie),
        .tcrFie           (fie),
        .tcrFp            (fp),
        .tcrAre           (are),
        .timerStatusOutL2 (tsr),
        .pitWrEn          (pit_we),
        .pitWrData        (pit_data),
        .pitValue         (pitValue),
        .wdPulse          (wdPulse),
        .hwSetWdIntrp     (hwSetWdIntrp),
        .hwSetWdRst       (hwSetWdRst),
        .hwSetFitStatus   (hwSetFitStatus),
        .hwSetPitStatus   (hwSetPitStatus),
        .wdRstType        (wdRstType),
        .wdIntrpReq       (wdIntrpReq),
        .pitIntrpReq      (pitIntrpReq),
        .fitIntrpReq      (fitIntrpReq),
        .resetReq         (resetReq)
    );

    always #5 CB = ~CB;

    obs_t exp_q[$];
    int   n_cmp = 0, n_bad = 0;
    bit   armed = 0;

    // Reference model state
    int          WDT[4]  = '{15, 11, 7, 3};
    int          FTT[4]  = '{23, 19, 15, 11};
    logic [31:0] m_cnt, m_rel, m_prev_tb;
    logic [1:0]  m_prev_wp, m_prev_fp, m_wrc;
    int          m_hold_rem;
    bit          m_prev_hold;
    obs_t        e1, e2;

    function automatic obs_t actual();
        obs_t a;
        a.wd_pulse  = wdPulse;
        a.wd_intrp  = hwSetWdIntrp;
        a.wd_rst    = hwSetWdRst;
        a.rst_type  = wdRstType;
        a.fit       = hwSetFitStatus;
        a.pit       = hwSetPitStatus;
        a.wd_irq    = wdIntrpReq;
        a.pit_irq   = pitIntrpReq;
        a.fit_irq   = fitIntrpReq;
        a.reset_req = resetReq;
        a.pit_value = pitValue;
        return a;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, want);
        end
    endtask

    task automatic m_reset();
        m_cnt = '0; m_rel = '0; m_prev_tb = '0;
        m_prev_wp = '0; m_prev_fp = '0; m_wrc = '0;
        m_hold_rem = 0; m_prev_hold = 0;
        e1 = '0; e2 = '0;
    endtask

    // Status register behaviour: strobes visible in one cycle land a cycle later.
    task automatic tsr_advance();
        if (e2.wd_pulse) tsr[0] = 1'b1;
        if (e2.wd_intrp) tsr[1] = 1'b1;
        if (e2.wd_rst)   tsr[2:3] = e2.rst_type;
        if (e2.pit)      tsr[4] = 1'b1;
        if (e2.fit)      tsr[5] = 1'b1;
    endtask

    task automatic model_step();
        obs_t e = '0;
        bit sup = m_prev_hold;
        bit cur_hold = 0;
        bit wd_ev  = (wp == m_prev_wp) && tbl_v[31-WDT[wp]] && !m_prev_tb[31-WDT[wp]];
        bit fit_ev = (fp == m_prev_fp) && tbl_v[31-FTT[fp]] && !m_prev_tb[31-FTT[fp]];
        e.wd_irq  = tsr[1] & wie;
        e.pit_irq = tsr[4] & pie;
        e.fit_irq = tsr[5] & fie;
        if (m_hold_rem > 0) begin
            e.reset_req = m_wrc;
            m_hold_rem--;
            cur_hold = 1;
        end else if (wd_ev && !sup) begin
            if (!tsr[0]) e.wd_pulse = 1'b1;
            else if (!tsr[1]) begin e.wd_pulse = 1'b1; e.wd_intrp = 1'b1; end
            else if (tsr[2:3] == 2'b00 && wrc != 2'b00) begin
                e.wd_rst = 1'b1; e.rst_type = wrc; e.reset_req = wrc;
                m_wrc = wrc; m_hold_rem = HOLD - 1; cur_hold = 1;
            end else e.wd_pulse = 1'b1;
        end
        e.fit = fit_ev && !sup;
        if (pit_we) begin
            m_cnt = pit_data; m_rel = pit_data;
        end else if (tb_en) begin
            if (m_cnt > 1) m_cnt = m_cnt - 1;
            else if (m_cnt == 1) begin e.pit = 1'b1; m_cnt = are ? m_rel : 32'd0; end
        end
        e.pit_value = m_cnt;
        m_prev_hold = cur_hold;
        m_prev_tb = tbl_v; m_prev_wp = wp; m_prev_fp = fp;
        e2 = e1; e1 = e;
        exp_q.push_back(e);
    endtask

    // One clock: inputs are sampled by the model at the negedge, then left stable
    // across the posedge; returns shortly after the posedge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CB);
            tsr_advance();
            model_step();
            armed = 1;
            @(posedge CB);
            #2;
        end
    endtask

    always @(posedge CB) begin
        #1;
        if (armed) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL obs at %0t: output cycle with no expected entry", $time);
            end else begin
                obs_t w, a;
                w = exp_q.pop_front();
                a = actual();
                n_cmp++;
                if (a !== w) begin
                    n_bad++;
                    $display("FAIL obs at %0t: got pls%b int%b rst%b typ%b fit%b pit%b irq%b%b%b rr%b pv%0d / expected pls%b int%b rst%b typ%b fit%b pit%b irq%b%b%b rr%b pv%0d",
                        $time, a.wd_pulse, a.wd_intrp, a.wd_rst, a.rst_type, a.fit, a.pit,
                        a.wd_irq, a.pit_irq, a.fit_irq, a.reset_req, a.pit_value,
                        w.wd_pulse, w.wd_intrp, w.wd_rst, w.rst_type, w.fit, w.pit,
                        w.wd_irq, w.pit_irq, w.fit_irq, w.reset_req, w.pit_value);
                end
            end
        end
    end

    task automatic wd_edge(input logic [31:0] mask);
        tbl_v = '0; step(3);
        tbl_v = mask; step(3);
    endtask

    initial begin
        // Reset state with busy inputs that would otherwise change every output
        tsr = 6'b111111; wie = 1; pie = 1; fie = 1; pit_we = 1; pit_data = 7; tb_en = 1;
        tbl_v = 32'hFFFF_FFFF;
        m_reset();
        #12;
        chk("reset_outputs", 64'(actual()), 64'd0);
        chk("reset_pitvalue", 64'(pitValue), 64'd0);
        tsr = '0; wie = 0; pie = 0; fie = 0; pit_we = 0; pit_data = 0; tb_en = 0; tbl_v = '0;
        #1 resetCoreN = 1;

        // Watchdog escalation through a modelled TSR: ENW, then WIS, then reset
        wp = 2'b00; wrc = 2'b10; wie = 1;
        for (int k = 0; k < 3; k++) wd_edge(32'h0001_0000);
        tbl_v = '0; step(HOLD + 6);

        // WRC=00 with ENW=WIS=1: tick only
        tsr = 6'b110000; wrc = 2'b00;
        wd_edge(32'h0001_0000); step(3);

        // FIT on TBL[19], then a select change onto an already-high tap
        fie = 1; fp = 2'b01; tbl_v = '0; step(2);
        tbl_v = 32'h0000_1000; step(3);
        tbl_v = 32'h0000_1100; step(2);
        fp = 2'b00; step(3);

        // PIT auto-reload, one-shot, write collision and write of zero
        tb_en = 1; are = 1; pit_data = 3; pit_we = 1; step(1); pit_we = 0; step(8);
        are = 0; pit_we = 1; step(1); pit_we = 0; step(6);
        pit_we = 1; step(1); pit_we = 0; step(2);
        pit_data = 5; pit_we = 1; step(1); pit_we = 0; step(2);
        pit_data = 0; pit_we = 1; step(1); pit_we = 0; step(3);

        // Async reset ten cycles into a reset hold
        tsr = 6'b110000; wrc = 2'b01; wp = 2'b00;
        tbl_v = '0; step(3);
        tbl_v = 32'h0001_0000;
        for (int k = 0; k < 10 && m_hold_rem == 0; k++) step(1);
        step(9);
        resetCoreN = 0;
        #1 chk("resetreq_async_drop", 64'(resetReq), 64'd0);
        m_reset();
        #1 resetCoreN = 1;
        tsr = '0; tbl_v = '0; step(3);
        wd_edge(32'h0001_0000); step(3);

        // Randomized traffic with software clears of the status register
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) < 3) tbl_v = $urandom();
            if ($urandom_range(0, 32) == 0) wp = 2'($urandom());
            if ($urandom_range(0, 32) == 0) fp = 2'($urandom());
            if ($urandom_range(0, 19) == 0) wrc = 2'($urandom());
            if ($urandom_range(0, 19) == 0) {wie, pie, fie, are} = 4'($urandom());
            tb_en    = ($urandom_range(0, 3) != 0);
            pit_we   = ($urandom_range(0, 19) == 0);
            pit_data = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 6));
            if ($urandom_range(0, 49) == 0) tsr = tsr & 6'($urandom());
            if ($urandom_range(0, 199) == 0) tsr = 6'($urandom());
            step(1);
        end

        armed = 0;
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d expected entries never compared", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
